// File: rtl/wakeup_array_pkg.sv
// Shared sizing and entry type for the issue-queue wakeup array.
// WAKEUP_SELECTED_DST_EN adds a stored destination tag to each entry.
package wakeup_array_pkg;

    localparam int unsigned RS_ENTRIES = 8;
    localparam int unsigned PREG_W     = 6;
    localparam int unsigned NUM_BCAST  = 2;
    localparam int unsigned IDX_W      = $clog2(RS_ENTRIES);

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] src1_tag;
        logic              src1_rdy;
        logic [PREG_W-1:0] src2_tag;
        logic              src2_rdy;
`ifdef WAKEUP_SELECTED_DST_EN
        logic [PREG_W-1:0] dst_tag;
`endif
    } rs_wake_entry_t;

endpackage

// File: rtl/wakeup_tag_cmp.sv
// Compares one source tag against every broadcast port; match is set if any
// valid port carries the same tag.
module wakeup_tag_cmp
    import wakeup_array_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_BCAST
) (
    input  logic [PREG_W-1:0]           tag,
    input  logic [NUM_PORTS-1:0]        port_valid,
    input  logic [NUM_PORTS*PREG_W-1:0] port_tag,
    output logic                        match
);

    always_comb begin
        match = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_valid[k] && (port_tag[k*PREG_W +: PREG_W] == tag)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wakeup_array.sv
// Issue-queue wakeup stage: allocates entries on dispatch, snoops tag
// broadcasts and drives Select's request vector. Option: WAKEUP_SELECTED_DST_EN.
module wakeup_array
    import wakeup_array_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    input  logic [PREG_W-1:0]           disp_src1_tag,
    input  logic                        disp_src1_rdy,
    input  logic [PREG_W-1:0]           disp_src2_tag,
    input  logic                        disp_src2_rdy,
    input  logic [PREG_W-1:0]           disp_dst_tag,
    output logic                        disp_ready,
    output logic [IDX_W-1:0]            disp_index,
    input  logic [NUM_BCAST-1:0]        bcast_valid,
    input  logic [NUM_BCAST*PREG_W-1:0] bcast_tag,
    input  logic                        clear_en,
    input  logic [IDX_W-1:0]            clear_index,
    output logic [RS_ENTRIES-1:0]       request_vector,
    output logic [IDX_W:0]              occupancy
);

    rs_wake_entry_t          entries [RS_ENTRIES];
    logic [IDX_W:0]          occ_q;
    logic                    clear_hit;
    logic                    disp_fire;
    logic [RS_ENTRIES-1:0]   src1_hit;
    logic [RS_ENTRIES-1:0]   src2_hit;
    logic                    disp_src1_hit;
    logic                    disp_src2_hit;

    // Clears of invalid entries are ignored so occupancy cannot underflow.
    assign clear_hit = clear_en & ~flush & entries[clear_index].valid;
    assign disp_fire = disp_valid & disp_ready & ~flush;

`ifdef WAKEUP_SELECTED_DST_EN
    localparam int unsigned NUM_WAKE = NUM_BCAST + 1;
    logic [NUM_WAKE-1:0]        wake_valid;
    logic [NUM_WAKE*PREG_W-1:0] wake_tag;

    // The selected entry's destination acts as an extra same-cycle broadcast.
    assign wake_valid = {clear_hit, bcast_valid};
    assign wake_tag   = {entries[clear_index].dst_tag, bcast_tag};
`else
    localparam int unsigned NUM_WAKE = NUM_BCAST;
    logic [NUM_WAKE-1:0]        wake_valid;
    logic [NUM_WAKE*PREG_W-1:0] wake_tag;
    logic                       unused_dst_tag;

    assign wake_valid     = bcast_valid;
    assign wake_tag       = bcast_tag;
    assign unused_dst_tag = ^disp_dst_tag;
`endif

    for (genvar i = 0; i < RS_ENTRIES; i++) begin : g_entry
        wakeup_tag_cmp #(.NUM_PORTS(NUM_WAKE)) u_src1_cmp (
            .tag        (entries[i].src1_tag),
            .port_valid (wake_valid),
            .port_tag   (wake_tag),
            .match      (src1_hit[i])
        );
        wakeup_tag_cmp #(.NUM_PORTS(NUM_WAKE)) u_src2_cmp (
            .tag        (entries[i].src2_tag),
            .port_valid (wake_valid),
            .port_tag   (wake_tag),
            .match      (src2_hit[i])
        );
        assign request_vector[i] = entries[i].valid & entries[i].src1_rdy & entries[i].src2_rdy;
    end

    wakeup_tag_cmp #(.NUM_PORTS(NUM_WAKE)) u_disp_src1_cmp (
        .tag        (disp_src1_tag),
        .port_valid (wake_valid),
        .port_tag   (wake_tag),
        .match      (disp_src1_hit)
    );

    wakeup_tag_cmp #(.NUM_PORTS(NUM_WAKE)) u_disp_src2_cmp (
        .tag        (disp_src2_tag),
        .port_valid (wake_valid),
        .port_tag   (wake_tag),
        .match      (disp_src2_hit)
    );

    // Lowest-numbered free entry; falls back to 0 when full.
    always_comb begin
        disp_index = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!entries[i].valid) begin
                disp_index = IDX_W'(i);
            end
        end
    end

    assign disp_ready = (occ_q != (IDX_W+1)'(RS_ENTRIES));
    assign occupancy  = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            occ_q <= '0;
        end else if (flush) begin
            // Tags and ready bits are left stale; valid gates everything.
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
            occ_q <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (entries[i].valid && src1_hit[i]) begin
                    entries[i].src1_rdy <= 1'b1;
                end
                if (entries[i].valid && src2_hit[i]) begin
                    entries[i].src2_rdy <= 1'b1;
                end
                if (clear_hit && (clear_index == IDX_W'(i))) begin
                    entries[i].valid <= 1'b0;
                end
                if (disp_fire && (disp_index == IDX_W'(i))) begin
                    entries[i].valid    <= 1'b1;
                    entries[i].src1_tag <= disp_src1_tag;
                    entries[i].src2_tag <= disp_src2_tag;
                    entries[i].src1_rdy <= disp_src1_rdy | (disp_src1_tag == '0) | disp_src1_hit;
                    entries[i].src2_rdy <= disp_src2_rdy | (disp_src2_tag == '0) | disp_src2_hit;
`ifdef WAKEUP_SELECTED_DST_EN
                    entries[i].dst_tag  <= disp_dst_tag;
`endif
                end
            end
            occ_q <= occ_q + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(clear_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && clear_en) begin
            assert (entries[clear_index].valid);
        end
    end

endmodule

// File: tb/tb_wakeup_array.sv
// Scoreboard bench for wakeup_array: directed scenarios followed by random
// traffic, all checked against an entry-level reference model.
module tb_wakeup_array;
    import wakeup_array_pkg::*;

    localparam int N = RS_ENTRIES;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic                        disp_valid;
    logic [PREG_W-1:0]           disp_src1_tag;
    logic                        disp_src1_rdy;
    logic [PREG_W-1:0]           disp_src2_tag;
    logic                        disp_src2_rdy;
    logic [PREG_W-1:0]           disp_dst_tag;
    logic                        disp_ready;
    logic [IDX_W-1:0]            disp_index;
    logic [NUM_BCAST-1:0]        bcast_valid;
    logic [NUM_BCAST*PREG_W-1:0] bcast_tag;
    logic                        clear_en;
    logic [IDX_W-1:0]            clear_index;
    logic [N-1:0]                request_vector;
    logic [IDX_W:0]              occupancy;

    always #5 clk = ~clk;

    wakeup_array dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_src1_tag  (disp_src1_tag),
        .disp_src1_rdy  (disp_src1_rdy),
        .disp_src2_tag  (disp_src2_tag),
        .disp_src2_rdy  (disp_src2_rdy),
        .disp_dst_tag   (disp_dst_tag),
        .disp_ready     (disp_ready),
        .disp_index     (disp_index),
        .bcast_valid    (bcast_valid),
        .bcast_tag      (bcast_tag),
        .clear_en       (clear_en),
        .clear_index    (clear_index),
        .request_vector (request_vector),
        .occupancy      (occupancy)
    );

    typedef struct {
        int           due;
        logic [N-1:0] req;
        int           occ;
        logic         rdy;
        int           idx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: one record per entry.
    bit                m_valid [N];
    bit                m_r1    [N];
    bit                m_r2    [N];
    logic [PREG_W-1:0] m_t1    [N];
    logic [PREG_W-1:0] m_t2    [N];
    logic [PREG_W-1:0] m_dst   [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic bit woken(input logic [PREG_W-1:0] t, input bit sel_ok,
                                 input logic [PREG_W-1:0] sel_dst);
        for (int k = 0; k < NUM_BCAST; k++)
            if (bcast_valid[k] && bcast_tag[k*PREG_W +: PREG_W] == t) return 1'b1;
`ifdef WAKEUP_SELECTED_DST_EN
        if (sel_ok && sel_dst == t) return 1'b1;
`else
        if (sel_ok && sel_dst == t && 1'b0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Apply the model to the inputs currently driven and queue the state
    // the DUT must show after the coming edge.
    task automatic commit();
        exp_t              e;
        int                cnt  = m_count();
        int                fr   = m_free();
        bit                sel_ok;
        logic [PREG_W-1:0] sel_dst;
        bit                ov [N];
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
                m_t1[i] = '0; m_t2[i] = '0; m_dst[i] = '0;
            end
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
        end else begin
            ov      = m_valid;
            sel_ok  = clear_en && m_valid[clear_index];
            sel_dst = m_dst[clear_index];
            for (int i = 0; i < N; i++) begin
                if (ov[i] && woken(m_t1[i], sel_ok, sel_dst)) m_r1[i] = 1;
                if (ov[i] && woken(m_t2[i], sel_ok, sel_dst)) m_r2[i] = 1;
            end
            if (sel_ok) m_valid[clear_index] = 0;
            if (disp_valid && cnt < N) begin
                m_valid[fr] = 1;
                m_t1[fr]  = disp_src1_tag;
                m_t2[fr]  = disp_src2_tag;
                m_dst[fr] = disp_dst_tag;
                m_r1[fr]  = disp_src1_rdy || disp_src1_tag == 0 ||
                            woken(disp_src1_tag, sel_ok, sel_dst);
                m_r2[fr]  = disp_src2_rdy || disp_src2_tag == 0 ||
                            woken(disp_src2_tag, sel_ok, sel_dst);
            end
        end
        e.due = cyc + 1;
        for (int i = 0; i < N; i++) e.req[i] = m_valid[i] && m_r1[i] && m_r2[i];
        e.occ = m_count();
        e.rdy = (e.occ != N);
        e.idx = (m_free() < 0) ? 0 : m_free();
        sb.push_back(e);
    endtask

    // Monitor: state after each edge is compared half a cycle later.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("sb_req_vec",    int'(request_vector), int'(e.req));
            check("sb_occupancy",  int'(occupancy),      e.occ);
            check("sb_disp_ready", int'(disp_ready),     int'(e.rdy));
            check("sb_disp_index", int'(disp_index),     e.idx);
        end
    end

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        rst = 0; flush = 0; disp_valid = 0;
        disp_src1_tag = '0; disp_src1_rdy = 0;
        disp_src2_tag = '0; disp_src2_rdy = 0; disp_dst_tag = '0;
        bcast_valid = '0; bcast_tag = '0; clear_en = 0; clear_index = '0;
    endtask

    task automatic do_disp(input int t1, input bit r1, input int t2, input bit r2, input int dst);
        disp_valid    = 1;
        disp_src1_tag = PREG_W'(t1); disp_src1_rdy = r1;
        disp_src2_tag = PREG_W'(t2); disp_src2_rdy = r2;
        disp_dst_tag  = PREG_W'(dst);
    endtask

    task automatic do_bcast(input int port, input int t);
        bcast_valid[port] = 1'b1;
        bcast_tag[port*PREG_W +: PREG_W] = PREG_W'(t);
    endtask

    task automatic do_clear(input int idx);
        clear_en = 1; clear_index = IDX_W'(idx);
    endtask

    initial begin
        int r;
        rst = 1; flush = 0; disp_valid = 0; disp_src1_tag = '0; disp_src1_rdy = 0;
        disp_src2_tag = '0; disp_src2_rdy = 0; disp_dst_tag = '0;
        bcast_valid = '0; bcast_tag = '0; clear_en = 0; clear_index = '0;

        cyc_begin(); rst = 1; commit();

        // Dispatch with both sources ready.
        cyc_begin(); do_disp(3, 1, 0, 0, 0);
        check("t1_disp_index", int'(disp_index), 0);
        check("t1_disp_ready", int'(disp_ready), 1);
        commit();
        cyc_begin(); do_disp(5, 0, 0, 0, 0);
        check("t1_req_vec", int'(request_vector), 1);
        check("t1_occupancy", int'(occupancy), 1);
        commit();

        // Entry 1 woken by broadcast two cycles after dispatch.
        cyc_begin(); commit();
        cyc_begin(); do_bcast(1, 5);
        check("t2_req_before", int'(request_vector[1]), 0);
        commit();
        cyc_begin(); do_disp(7, 0, 0, 0, 0); do_bcast(0, 7);
        check("t2_req_after", int'(request_vector[1]), 1);
        commit();

        // Same-cycle bypass, then fill the array.
        cyc_begin();
        check("t3_bypass_req", int'(request_vector[2]), 1);
        do_disp(20, 1, 21, 1, 0); commit();
        for (int i = 4; i < N; i++) begin
            cyc_begin(); do_disp(20 + i, 1, 30, 1, 0); commit();
        end
        cyc_begin();
        check("t4_full_ready", int'(disp_ready), 0);
        check("t4_full_occ", int'(occupancy), N);
        do_disp(40, 1, 41, 1, 0); commit();
        cyc_begin();
        check("t4_drop_occ", int'(occupancy), N);
        do_clear(3); do_disp(40, 1, 41, 1, 0);
        check("t4_full_clear_ready", int'(disp_ready), 0);
        commit();
        cyc_begin();
        check("t4_after_clear_ready", int'(disp_ready), 1);
        check("t4_after_clear_index", int'(disp_index), 3);
        check("t4_after_clear_occ", int'(occupancy), N - 1);
        do_clear(0); commit();
        cyc_begin(); do_clear(1); commit();
        cyc_begin(); do_clear(2); commit();

        // Dispatch and clear together at occupancy 4.
        cyc_begin();
        check("t5_occ_before", int'(occupancy), 4);
        do_disp(1, 1, 2, 1, 0); do_clear(4); commit();
        cyc_begin();
        check("t5_occ_same", int'(occupancy), 4);
        do_disp(1, 1, 2, 1, 0); commit();
        cyc_begin(); do_disp(1, 1, 2, 1, 0); commit();

        // Flush with a concurrent dispatch.
        cyc_begin();
        check("t6_occ_before_flush", int'(occupancy), 6);
        flush = 1; do_disp(1, 1, 2, 1, 0); commit();
        cyc_begin();
        check("t6_flush_req", int'(request_vector), 0);
        check("t6_flush_occ", int'(occupancy), 0);
        check("t6_flush_index", int'(disp_index), 0);
        commit();

        // Selected-entry destination wakeup.
        cyc_begin(); do_disp(1, 1, 0, 0, 9); commit();
        cyc_begin(); do_disp(9, 0, 0, 0, 0); commit();
        cyc_begin();
        check("t7_req_before", int'(request_vector), 1);
        do_clear(0); commit();
        cyc_begin();
`ifdef WAKEUP_SELECTED_DST_EN
        check("t7_sel_dst_wake", int'(request_vector), 2);
        commit();
`else
        check("t7_no_sel_wake", int'(request_vector), 0);
        do_bcast(0, 9); commit();
        cyc_begin();
        check("t7_ext_wake", int'(request_vector), 2);
        commit();
`endif

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            cyc_begin();
            if ($urandom_range(0, 99) < 60)
                do_disp($urandom_range(0, 15), $urandom_range(0, 3) == 0,
                        $urandom_range(0, 15), $urandom_range(0, 3) == 0,
                        $urandom_range(0, 15));
            for (int k = 0; k < NUM_BCAST; k++)
                if ($urandom_range(0, 2) == 0) do_bcast(k, $urandom_range(0, 15));
            if ($urandom_range(0, 99) < 45 && m_count() > 0) begin
                r = $urandom_range(0, N - 1);
                while (!m_valid[r]) r = (r + 1) % N;
                do_clear(r);
            end
            flush = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            commit();
        end

        cyc_begin(); commit();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
